keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces the
// column pattern and exposes the accepted keycode plus ready/overrun status.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        readyclr,
  input  logic        a0,
  output logic [15:0] dataout
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_CNT);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StHold} state_e;

  state_e          state_q, state_d;
  logic [3:0]      col_meta_q, col_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      key_q, key_d;
  logic            ready_q, ready_d;
  logic            ovr_q, ovr_d;
  logic            tick;
  logic            accept;
  logic [3:0]      accept_pat;

  // Lowest column index whose bit is low in an active-low pattern.
  function automatic logic [1:0] low_col(input logic [3:0] p);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!p[i]) c = 2'(i);
    end
    return c;
  endfunction

  assign tick  = (div_q == DivLast);
  assign div_d = tick ? '0 : div_q + DivW'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and scan datapath decisions, evaluated only at sample ticks.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    accept     = 1'b0;
    accept_pat = pat_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (col_sync_q == 4'hF) begin
            row_d = row_q + 2'd1;
          end else begin
            pat_d = col_sync_q;
            if (CntTarget == CntOne) begin
              // Single-sample debounce accepts on the first press sample.
              accept     = 1'b1;
              accept_pat = col_sync_q;
              cnt_d      = '0;
              state_d    = StHold;
            end else begin
              cnt_d   = CntOne;
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (col_sync_q == pat_q) begin
            if (cnt_q + CntOne == CntTarget) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = StHold;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            row_d   = row_q + 2'd1;
            cnt_d   = '0;
            state_d = StScan;
          end
        end
        StHold: begin
          if (col_sync_q == 4'hF) begin
            if (cnt_q + CntOne == CntTarget) begin
              row_d   = row_q + 2'd1;
              cnt_d   = '0;
              state_d = StScan;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = StScan;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: row drive, bus read mux, and keycode/status updates on accept.
  always_comb begin
    key_d   = key_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    if (accept) begin
      key_d   = {row_q, low_col(accept_pat)};
      ready_d = 1'b1;
      // A clear on the same edge wins over the overrun condition.
      ovr_d   = readyclr ? 1'b0 : (ovr_q | ready_q);
    end else if (readyclr) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
    rowwrite = ~(4'b0001 << row_q);
    dataout  = a0 ? {14'b0, ovr_q, ready_q} : {12'b0, key_q};
  end

  // Synchronizer, slot timer and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      div_q      <= '0;
      row_q      <= 2'd0;
      cnt_q      <= '0;
      pat_q      <= 4'hF;
      key_q      <= 4'd0;
      ready_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      col_meta_q <= colread;
      col_sync_q <= col_meta_q;
      div_q      <= div_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      key_q      <= key_d;
      ready_q    <= ready_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad matrix drives colread from the
// driven row, a behavioural model predicts rowwrite/dataout every cycle, and
// directed scenarios pin literal expectations.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic        readyclr;
  logic        a0;
  logic [15:0] dataout;
  logic [15:0] keys;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  int         m_div, m_row, m_mode, m_cnt, m_key, m_rdy, m_ovr;
  logic [3:0] m_pat, m_s1, m_s2;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rowwrite (rowwrite),
    .colread  (colread),
    .readyclr (readyclr),
    .a0       (a0),
    .dataout  (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rowwrite[r] && keys[4*r+c]) colread[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] p);
    for (int c = 0; c < 4; c++) begin
      if (!p[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_div = 0; m_row = 0; m_mode = 0; m_cnt = 0;
    m_key = 0; m_rdy = 0; m_ovr = 0;
    m_pat = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  // One clock of the keypad rules: 0 = scanning, 1 = debouncing, 2 = holding.
  task automatic model_step();
    logic [3:0] cs;
    bit         acc;
    int         kc;
    cs  = m_s2;
    acc = 0;
    kc  = 0;
    if (m_div == SCAN_DIV - 1) begin
      case (m_mode)
        0: begin
          if (cs == 4'hF) m_row = (m_row + 1) % 4;
          else begin m_pat = cs; m_cnt = 1; m_mode = 1; end
        end
        1: begin
          if (cs == m_pat) m_cnt++;
          else begin m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4; end
        end
        default: begin
          if (cs != 4'hF) m_cnt = 0;
          else begin
            m_cnt++;
            if (m_cnt == DB) begin m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4; end
          end
        end
      endcase
      if (m_mode == 1 && m_cnt == DB) begin
        acc = 1; m_mode = 2; m_cnt = 0;
        kc = 4 * m_row + lowest(m_pat);
      end
    end
    if (acc) begin
      m_ovr = readyclr ? 0 : ((m_rdy != 0) ? 1 : m_ovr);
      m_rdy = 1;
      m_key = kc;
    end else if (readyclr) begin
      m_rdy = 0; m_ovr = 0;
    end
    m_div = (m_div + 1) % SCAN_DIV;
    m_s2  = m_s1;
    m_s1  = colread;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, just after the active edge.
  always @(posedge clk) begin
    logic [3:0]  exp_rw;
    logic [15:0] exp_do;
    #1;
    exp_rw = 4'hF;
    exp_rw[m_row[1:0]] = 1'b0;
    exp_do = a0 ? 16'(m_ovr * 2 + m_rdy) : 16'(m_key);
    check("model rowwrite", {12'b0, rowwrite}, {12'b0, exp_rw});
    check("model dataout", dataout, exp_do);
  end

  task automatic read(input logic sel, input string name, input logic [15:0] exp);
    a0 = sel;
    #1;
    check(name, dataout, exp);
  endtask

  task automatic slots(input int k);
    repeat (k * SCAN_DIV) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); readyclr = 1'b1;
    @(negedge clk); readyclr = 1'b0;
  endtask

  // Wait for a negedge where the given row has just started its slot.
  task automatic wait_row(input logic [3:0] rw);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rowwrite == rw && m_div == 0) && n < 200);
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_row timeout: got rowwrite %b required %b", rowwrite, rw);
    end
  endtask

  initial begin
    rst_n = 1'b0; keys = '0; readyclr = 1'b0; a0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset rowwrite", {12'b0, rowwrite}, 16'h000E);
    read(1'b0, "reset keycode", 16'h0000);
    read(1'b1, "reset status", 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Short press on row 0: two matching samples then release, no key.
    wait_row(4'b1110);
    keys[0] = 1'b1; slots(2);
    keys[0] = 1'b0; slots(1);
    check("bounce row advance", {12'b0, rowwrite}, 16'h000D);
    read(1'b1, "bounce status", 16'h0000);

    // Key 6: row 1, column 2.
    wait_row(4'b1101);
    keys[6] = 1'b1; slots(3);
    read(1'b1, "key6 status", 16'h0001);
    read(1'b0, "key6 keycode", 16'h0006);
    slots(4);
    check("key6 row frozen", {12'b0, rowwrite}, 16'h000D);
    keys[6] = 1'b0; slots(3);
    check("key6 release advance", {12'b0, rowwrite}, 16'h000B);

    // Key 3 then key 12 without clearing: overrun.
    pulse_clr();
    read(1'b1, "clear status", 16'h0000);
    keys[3] = 1'b1; repeat (60) @(negedge clk);
    read(1'b0, "key3 keycode", 16'h0003);
    read(1'b1, "key3 status", 16'h0001);
    keys[3] = 1'b0; repeat (30) @(negedge clk);
    keys[12] = 1'b1; repeat (60) @(negedge clk);
    read(1'b0, "key12 keycode", 16'h000C);
    read(1'b1, "key12 overrun status", 16'h0003);
    pulse_clr();
    read(1'b1, "readyclr status", 16'h0000);
    keys[12] = 1'b0; repeat (30) @(negedge clk);

    // Clear coinciding with an accept while ready is already set.
    wait_row(4'b1110);
    keys[1] = 1'b1; slots(3);
    read(1'b1, "key1 status", 16'h0001);
    keys[1] = 1'b0; slots(4);
    wait_row(4'b1110);
    keys[2] = 1'b1;
    repeat (11) @(negedge clk);
    readyclr = 1'b1;
    @(negedge clk); readyclr = 1'b0;
    read(1'b1, "set wins status", 16'h0001);
    read(1'b0, "set wins keycode", 16'h0002);
    keys[2] = 1'b0; repeat (30) @(negedge clk);

    // Two columns on row 2, then a bouncing release.
    pulse_clr();
    wait_row(4'b1011);
    keys[9] = 1'b1; keys[11] = 1'b1; slots(3);
    read(1'b0, "multi keycode", 16'h0009);
    keys[9] = 1'b0; keys[11] = 1'b0; slots(1);
    keys[9] = 1'b1; slots(1);
    keys[9] = 1'b0; slots(2);
    check("release bounce held", {12'b0, rowwrite}, 16'h000B);
    slots(1);
    check("release bounce done", {12'b0, rowwrite}, 16'h0007);

    // Asynchronous reset mid-HOLD.
    pulse_clr();
    wait_row(4'b1101);
    keys[5] = 1'b1; slots(3);
    read(1'b0, "key5 keycode", 16'h0005);
    slots(1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset rowwrite", {12'b0, rowwrite}, 16'h000E);
    read(1'b1, "async reset status", 16'h0000);
    read(1'b0, "async reset keycode", 16'h0000);
    keys[5] = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(negedge clk);
    read(1'b1, "post reset status", 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
